// File: rtl/credential_step_ctrl.sv
// credential_step_ctrl: compares the switch input against a loadable
// credential through an external ALU, then steps a counter up or down
// (wrapping or saturating) through the same ALU. A round is started with
// iEn and finished with a one-cycle oValid pulse; oBusy covers the round.
module credential_step_ctrl #(
    parameter int unsigned      WIDTH      = 4,
    parameter logic [WIDTH-1:0] CREDENTIAL = WIDTH'(2),
    parameter int unsigned      STEP       = 1,
    parameter bit               WRAP_MODE  = 1'b1,
    parameter int unsigned      ALU_LAT    = 1,
    parameter logic [3:0]       OP_SUB     = 4'b0000,
    parameter logic [3:0]       OP_ADD     = 4'b1100
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iEn,
    input  logic [WIDTH-1:0] iID,
    input  logic             iCredLoad,
    input  logic [WIDTH-1:0] iCredVal,
    input  logic [WIDTH-1:0] iAluResult,
    input  logic [4:0]       iAluFlags,
    output logic [WIDTH-1:0] oAluA,
    output logic [WIDTH-1:0] oAluB,
    output logic [3:0]       oOpcode,
    output logic [WIDTH-1:0] oCount,
    output logic             oMatch,
    output logic             oValid,
    output logic             oBusy
);

    // Latency counter is wide enough to hold ALU_LAT-1; one bit minimum.
    localparam int unsigned      LAT_W    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ALU_LAT - 1);
    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] MAX_W    = '1;
    localparam logic [WIDTH-1:0] UP_LIMIT = MAX_W - STEP_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMP,
        S_DECIDE,
        S_STEP,
        S_COMMIT
    } stateE;

    stateE            state_q;
    logic [LAT_W-1:0] latCnt_q;
    logic [WIDTH-1:0] credential_q;
    logic [WIDTH-1:0] aluA_q;
    logic [WIDTH-1:0] aluB_q;
    logic [3:0]       opcode_q;
    logic [WIDTH-1:0] count_q;
    logic             match_q;
    logic             valid_q;
    logic             busy_q;
    logic             zero_q;
    logic             neg_q;
    logic             dirUp_q;
    logic [WIDTH-1:0] countStep_d;

    // Only the zero and borrow flags steer the FSM; the rest are ignored.
    logic unusedFlags;
    assign unusedFlags = ^{iAluFlags[4:3], iAluFlags[1]};

    // Next count value; saturation is judged from the pre-step count still
    // held on operand A, so it does not depend on ALU carry semantics.
    always_comb begin
        countStep_d = iAluResult;
        if (!WRAP_MODE) begin
            if (dirUp_q) begin
                if (aluA_q > UP_LIMIT) begin
                    countStep_d = MAX_W;
                end
            end else if (aluA_q < STEP_W) begin
                countStep_d = '0;
            end
        end
    end

    // Round sequencer: every output is a register updated here.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q      <= S_IDLE;
            latCnt_q     <= '0;
            credential_q <= CREDENTIAL;
            aluA_q       <= '0;
            aluB_q       <= '0;
            opcode_q     <= OP_SUB;
            count_q      <= '0;
            match_q      <= 1'b0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            zero_q       <= 1'b0;
            neg_q        <= 1'b0;
            dirUp_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (iCredLoad) begin
                        credential_q <= iCredVal;
                    end else if (iEn) begin
                        aluA_q   <= iID;
                        aluB_q   <= credential_q;
                        opcode_q <= OP_SUB;
                        latCnt_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_CMP;
                    end
                end
                S_CMP: begin
                    if (latCnt_q == LAT_LAST) begin
                        zero_q  <= iAluFlags[0];
                        neg_q   <= iAluFlags[2];
                        state_q <= S_DECIDE;
                    end else begin
                        latCnt_q <= latCnt_q + LAT_W'(1);
                    end
                end
                S_DECIDE: begin
                    // Zero wins over borrow, so the illegal Z&N case is a match.
                    if (zero_q) begin
                        match_q <= 1'b1;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        aluA_q   <= count_q;
                        aluB_q   <= STEP_W;
                        opcode_q <= neg_q ? OP_SUB : OP_ADD;
                        dirUp_q  <= !neg_q;
                        latCnt_q <= '0;
                        state_q  <= S_STEP;
                    end
                end
                S_STEP: begin
                    if (latCnt_q == LAT_LAST) begin
                        count_q <= countStep_d;
                        match_q <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= S_COMMIT;
                    end else begin
                        latCnt_q <= latCnt_q + LAT_W'(1);
                    end
                end
                S_COMMIT: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign oAluA   = aluA_q;
    assign oAluB   = aluB_q;
    assign oOpcode = opcode_q;
    assign oCount  = count_q;
    assign oMatch  = match_q;
    assign oValid  = valid_q;
    assign oBusy   = busy_q;

endmodule

// File: tb/tb_credential_step_ctrl.sv
// tb_credential_step_ctrl: four instances of the controller with different
// step/wrap/latency settings, each driven by its own behavioural ALU that
// returns X until its operands have been stable for the configured latency.
module tb_credential_step_ctrl;

    localparam int N = 4;
    localparam int P_STEP [N] = '{1, 1, 3, 3};
    localparam bit P_WRAP [N] = '{1'b1, 1'b0, 1'b0, 1'b1};
    localparam int P_LAT  [N] = '{1, 1, 1, 3};

    logic       clk = 1'b0;
    logic       rstN     [N];
    logic       en       [N];
    logic [3:0] id       [N];
    logic       credLoad [N];
    logic [3:0] credVal  [N];
    logic [3:0] aluRes   [N];
    logic [4:0] aluFlags [N];
    logic [3:0] aluA     [N];
    logic [3:0] aluB     [N];
    logic [3:0] opc      [N];
    logic [3:0] count    [N];
    logic       match    [N];
    logic       valid    [N];
    logic       busy     [N];

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [3:0] cnt;
        logic       m;
    } expT;
    expT sbQ[$];

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : gDut
        logic [11:0] snapOps;
        int          age = 0;
        logic [3:0]  rawRes;
        logic [4:0]  rawFlags;
        logic        settled;

        credential_step_ctrl #(
            .WIDTH     (4),
            .CREDENTIAL(4'd2),
            .STEP      (P_STEP[g]),
            .WRAP_MODE (P_WRAP[g]),
            .ALU_LAT   (P_LAT[g]),
            .OP_SUB    (4'b0000),
            .OP_ADD    (4'b1100)
        ) uDut (
            .iClk      (clk),
            .iRst_n    (rstN[g]),
            .iEn       (en[g]),
            .iID       (id[g]),
            .iCredLoad (credLoad[g]),
            .iCredVal  (credVal[g]),
            .iAluResult(aluRes[g]),
            .iAluFlags (aluFlags[g]),
            .oAluA     (aluA[g]),
            .oAluB     (aluB[g]),
            .oOpcode   (opc[g]),
            .oCount    (count[g]),
            .oMatch    (match[g]),
            .oValid    (valid[g]),
            .oBusy     (busy[g])
        );

        // Track how many edges the ALU operands have been unchanged.
        always @(posedge clk) begin
            snapOps <= {aluA[g], aluB[g], opc[g]};
            if ({aluA[g], aluB[g], opc[g]} !== snapOps) age <= 1;
            else if (age < 1000) age <= age + 1;
        end

        // Behavioural ALU: add for 1100, subtract otherwise.
        always_comb begin
            rawRes      = (opc[g] == 4'b1100) ? aluA[g] + aluB[g] : aluA[g] - aluB[g];
            rawFlags    = '0;
            rawFlags[0] = (rawRes == 4'd0);
            rawFlags[2] = (opc[g] == 4'b0000) && (aluA[g] < aluB[g]);
            settled     = ({aluA[g], aluB[g], opc[g]} === snapOps) ? (age >= P_LAT[g] - 1)
                                                                   : (P_LAT[g] == 1);
        end

        assign aluRes[g]   = settled ? rawRes : 4'bxxxx;
        assign aluFlags[g] = settled ? rawFlags : 5'bxxxxx;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for the next oValid pulse; waited counts negedges.
    task automatic awaitValid(input int d, input int budget, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (valid[d] !== 1'b1 && waited < budget);
        check($sformatf("d%0d_validSeen", d), valid[d], 1);
    endtask

    // Pop the scoreboard at the pulse, then confirm the pulse is one cycle wide.
    task automatic checkOutput(input int d, input int expWait);
        int  waited;
        expT e;
        awaitValid(d, 20, waited);
        check($sformatf("d%0d_latency", d), waited, expWait);
        e = sbQ.pop_front();
        check($sformatf("d%0d_count", d), count[d], e.cnt);
        check($sformatf("d%0d_match", d), match[d], e.m);
        @(negedge clk);
        check($sformatf("d%0d_validPulse", d), valid[d], 0);
        check($sformatf("d%0d_idleBusy", d), busy[d], 0);
    endtask

    // One round: pulse iEn for one edge and record the expected outcome.
    task automatic applyStimulus(input int d, input logic [3:0] idVal,
                                 input logic [3:0] cnt, input logic m, input int expWait);
        id[d] = idVal;
        en[d] = 1'b1;
        sbQ.push_back('{cnt, m});
        @(negedge clk);
        en[d] = 1'b0;
        checkOutput(d, expWait);
    endtask

    initial begin
        int waited;
        for (int i = 0; i < N; i++) begin
            rstN[i] = 1'b0; en[i] = 1'b0; id[i] = '0; credLoad[i] = 1'b0; credVal[i] = '0;
        end
        #12;
        for (int i = 0; i < N; i++) begin
            check($sformatf("d%0d_rstCount", i), count[i], 0);
            check($sformatf("d%0d_rstBusy", i), busy[i], 0);
            check($sformatf("d%0d_rstValid", i), valid[i], 0);
        end
        check("rstOpcode", opc[0], 4'b0000);
        check("rstAluA", aluA[0], 0);
        check("rstAluB", aluB[0], 0);
        check("rstMatch", match[0], 0);
        @(negedge clk);
        for (int i = 0; i < N; i++) rstN[i] = 1'b1;
        @(negedge clk);

        $display("[TB] wrap down from 0 and wrap up from 15");
        applyStimulus(0, 4'd0, 4'd15, 1'b0, 3);
        applyStimulus(0, 4'd5, 4'd0, 1'b0, 3);

        $display("[TB] iEn held for three stepping rounds");
        id[0] = 4'd5;
        en[0] = 1'b1;
        sbQ.push_back('{4'd1, 1'b0});
        sbQ.push_back('{4'd2, 1'b0});
        sbQ.push_back('{4'd3, 1'b0});
        repeat (3) @(negedge clk);
        check("heldStepOpcode", opc[0], 4'b1100);
        check("heldStepAluA", aluA[0], 0);
        check("heldStepAluB", aluB[0], 1);
        check("heldStepBusy", busy[0], 1);
        for (int r = 0; r < 3; r++) begin
            expT e;
            awaitValid(0, 10, waited);
            check($sformatf("heldPeriod%0d", r), waited, (r == 0) ? 1 : 5);
            e = sbQ.pop_front();
            check($sformatf("heldCount%0d", r), count[0], e.cnt);
        end
        en[0] = 1'b0;
        @(negedge clk);
        check("heldEndValid", valid[0], 0);
        check("heldEndBusy", busy[0], 0);

        $display("[TB] match round then stepping round clears match");
        applyStimulus(0, 4'd2, 4'd3, 1'b1, 2);
        applyStimulus(0, 4'd7, 4'd4, 1'b0, 3);

        $display("[TB] credential load while busy and with iEn in idle");
        id[0] = 4'd2;
        en[0] = 1'b1;
        sbQ.push_back('{4'd4, 1'b1});
        @(negedge clk);
        en[0] = 1'b0; credLoad[0] = 1'b1; credVal[0] = 4'd9;
        @(negedge clk);
        credLoad[0] = 1'b0;
        check("busyLoadBusy", busy[0], 1);
        checkOutput(0, 1);
        credLoad[0] = 1'b1; credVal[0] = 4'd9; en[0] = 1'b1; id[0] = 4'd5;
        @(negedge clk);
        check("loadOnlyBusy", busy[0], 0);
        credLoad[0] = 1'b0; en[0] = 1'b0;
        @(negedge clk);
        check("loadOnlyBusyLater", busy[0], 0);
        check("loadOnlyValid", valid[0], 0);
        applyStimulus(0, 4'd9, 4'd4, 1'b1, 2);
        applyStimulus(0, 4'd2, 4'd3, 1'b0, 3);

        $display("[TB] saturating, step 1");
        applyStimulus(1, 4'd0, 4'd0, 1'b0, 3);
        applyStimulus(1, 4'd5, 4'd1, 1'b0, 3);
        applyStimulus(1, 4'd0, 4'd0, 1'b0, 3);

        $display("[TB] saturating, step 3");
        applyStimulus(2, 4'd0, 4'd0, 1'b0, 3);
        for (int k = 1; k <= 5; k++) applyStimulus(2, 4'd9, 4'(3 * k), 1'b0, 3);
        applyStimulus(2, 4'd9, 4'd15, 1'b0, 3);
        applyStimulus(2, 4'd0, 4'd12, 1'b0, 3);

        $display("[TB] wrapping, step 3, ALU latency 3");
        applyStimulus(3, 4'd6, 4'd3, 1'b0, 7);
        for (int k = 2; k <= 10; k++) applyStimulus(3, 4'd9, 4'(3 * k), 1'b0, 7);
        applyStimulus(3, 4'd9, 4'd1, 1'b0, 7);
        applyStimulus(3, 4'd2, 4'd1, 1'b1, 4);

        $display("[TB] async reset during STEP");
        id[3] = 4'd6;
        en[3] = 1'b1;
        @(negedge clk);
        en[3] = 1'b0;
        repeat (5) @(negedge clk);
        check("midStepOpcode", opc[3], 4'b1100);
        rstN[3] = 1'b0;
        #1;
        check("midRstCount", count[3], 0);
        check("midRstBusy", busy[3], 0);
        check("midRstMatch", match[3], 0);
        check("midRstOpcode", opc[3], 4'b0000);
        check("midRstAluA", aluA[3], 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("midRstNoValid%0d", i), valid[3], 0);
        end
        rstN[3] = 1'b1;
        @(negedge clk);
        check("postRstBusy", busy[3], 0);
        applyStimulus(3, 4'd9, 4'd3, 1'b0, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
